// File: rtl/quanet_pulse_seq_pkg.sv
// Shared state encoding and default sizing for the pulse sequencer.
package quanet_pulse_seq_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_REPS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/quanet_pulse_ch.sv
// One pulse channel: window compare against the shared frame counter, registered output.
// The sum dly+width is formed one bit wider so a window near the counter limit cannot wrap.
module quanet_pulse_ch
  import quanet_pulse_seq_pkg::*;
#(
  parameter int   CNT_W = DEF_CNT_W,
  parameter logic INV   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] frame_cnt,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] width,
  output logic             pulse_out
);

  logic [CNT_W:0] win_end;
  logic           active;
  logic           pulse_d;
  logic           pulse_q;

  always_comb begin
    win_end = {1'b0, dly} + {1'b0, width};
    active  = en && (width != '0) && (dly < period) &&
              (frame_cnt >= dly) && ({1'b0, frame_cnt} < win_end);
    pulse_d = active ^ INV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_q <= INV;
    else     pulse_q <= pulse_d;
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/quanet_pulse_seq.sv
// Triggered multi-channel pulse sequencer: IDLE/ARMED/RUN FSM, frame and repetition
// counters, shadowed run configuration, one window channel per output.
module quanet_pulse_seq
  import quanet_pulse_seq_pkg::*;
#(
  parameter int                NUM_CH   = DEF_NUM_CH,
  parameter int                CNT_W    = DEF_CNT_W,
  parameter int                REPS_W   = DEF_REPS_W,
  parameter logic [NUM_CH-1:0] INV_MASK = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    rearm,
  input  logic                    trig_in,
  input  logic [CNT_W-1:0]        period,
  input  logic [REPS_W-1:0]       reps,
  input  logic [NUM_CH*CNT_W-1:0] dly,
  input  logic [NUM_CH*CNT_W-1:0] width,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic                    busy,
  output logic                    armed,
  output logic                    done,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [REPS_W-1:0] REP_ONE = REPS_W'(1);

  seq_state_t              state_q, state_d;
  logic                    trig_prev_q, trig_prev_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [REPS_W-1:0]       rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0]        sh_period_q, sh_period_d;
  logic [REPS_W-1:0]       sh_reps_q, sh_reps_d;
  logic [NUM_CH*CNT_W-1:0] sh_dly_q, sh_dly_d;
  logic [NUM_CH*CNT_W-1:0] sh_width_q, sh_width_d;
  logic                    fin_q, fin_d;
  logic                    busy_q, busy_d;
  logic                    armed_q, armed_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;

  logic                    trig_rise;
  logic                    in_run;
  logic                    wrap;
  logic                    last_rep;
  logic [REPS_W-1:0]       rep_nxt;

  always_comb begin
    state_d     = state_q;
    trig_prev_d = trig_in;
    frame_cnt_d = frame_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    sh_period_d = sh_period_q;
    sh_reps_d   = sh_reps_q;
    sh_dly_d    = sh_dly_q;
    sh_width_d  = sh_width_q;
    fin_d       = 1'b0;
    overrun_d   = overrun_q;

    trig_rise = trig_in && !trig_prev_q;
    in_run    = (state_q == ST_RUN);
    wrap      = (frame_cnt_q == sh_period_q - CNT_ONE);
    rep_nxt   = rep_cnt_q + REP_ONE;
    last_rep  = (sh_reps_q != '0) && (rep_nxt == sh_reps_q);

    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      // fin_q/done_q mark the two cycles right after a rearmed completion,
      // during which a new trigger is still refused.
      ST_ARMED: begin
        if (trig_rise && !fin_q && !done_q) begin
          state_d     = ST_RUN;
          sh_period_d = (period == '0) ? CNT_ONE : period;
          sh_reps_d   = reps;
          sh_dly_d    = dly;
          sh_width_d  = width;
          frame_cnt_d = '0;
          rep_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          frame_cnt_d = '0;
          rep_cnt_d   = rep_nxt;
          if (last_rep) begin
            state_d   = rearm ? ST_ARMED : ST_IDLE;
            fin_d     = 1'b1;
            rep_cnt_d = '0;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      fin_d       = 1'b0;
      frame_cnt_d = '0;
      rep_cnt_d   = '0;
    end

    if (arm)                overrun_d = 1'b0;
    if (in_run && trig_rise) overrun_d = 1'b1;

    // Status outputs share the one-cycle lag of the channel output registers.
    busy_d  = in_run && !abort;
    armed_d = (state_q == ST_ARMED) && !abort;
    done_d  = fin_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trig_prev_q <= 1'b1;
      frame_cnt_q <= '0;
      rep_cnt_q   <= '0;
      sh_period_q <= '0;
      sh_reps_q   <= '0;
      sh_dly_q    <= '0;
      sh_width_q  <= '0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      frame_cnt_q <= frame_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      sh_period_q <= sh_period_d;
      sh_reps_q   <= sh_reps_d;
      sh_dly_q    <= sh_dly_d;
      sh_width_q  <= sh_width_d;
      fin_q       <= fin_d;
      busy_q      <= busy_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    quanet_pulse_ch #(
      .CNT_W (CNT_W),
      .INV   (INV_MASK[c])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (busy_d),
      .frame_cnt (frame_cnt_q),
      .period    (sh_period_q),
      .dly       (sh_dly_q[c*CNT_W +: CNT_W]),
      .width     (sh_width_q[c*CNT_W +: CNT_W]),
      .pulse_out (pulse_out[c])
    );
  end

  assign busy    = busy_q;
  assign armed   = armed_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
